// File: rtl/keypad_dir_buffer.sv
// keypad_dir_buffer: debounces keypad direction presses frame by frame, holds
// one perpendicular turn as pending until the player is free to take it, and
// drives the one-hot direction vector and facing code for the movement block.
module keypad_dir_buffer #(
  parameter int DEBOUNCE_FRAMES        = 2,
  parameter int PENDING_TIMEOUT_FRAMES = 15
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] keyCode,
  input  logic       keyIsPressed,
  input  logic       collision,
  input  logic       reset,
  input  logic       stop,
  output logic [9:0] dirKeys,
  output logic [1:0] dirCode,
  output logic       pendingValid
);

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {WAIT_ST, COUNT_ST, HELD_ST} db_st_t;

  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE_FRAMES);
  localparam logic [5:0] TMO_LIM = 6'(PENDING_TIMEOUT_FRAMES);
  localparam logic [3:0] KEY_HALT = 4'd5;

  function automatic logic is_valid_key(input logic [3:0] k);
    is_valid_key = (k == 4'd2) || (k == 4'd4) || (k == 4'd5) ||
                   (k == 4'd6) || (k == 4'd8);
  endfunction

  function automatic dir_t key_to_dir(input logic [3:0] k);
    case (k)
      4'd8:    key_to_dir = DIR_UP;
      4'd2:    key_to_dir = DIR_DOWN;
      4'd4:    key_to_dir = DIR_LEFT;
      4'd6:    key_to_dir = DIR_RIGHT;
      default: key_to_dir = DIR_NONE;
    endcase
  endfunction

  function automatic dir_t reverse_of(input dir_t d);
    case (d)
      DIR_UP:    reverse_of = DIR_DOWN;
      DIR_DOWN:  reverse_of = DIR_UP;
      DIR_LEFT:  reverse_of = DIR_RIGHT;
      DIR_RIGHT: reverse_of = DIR_LEFT;
      default:   reverse_of = DIR_NONE;
    endcase
  endfunction

  // Bit index matches the keypad digit of the direction.
  function automatic logic [9:0] dir_to_keys(input dir_t d);
    case (d)
      DIR_UP:    dir_to_keys = 10'h100;
      DIR_DOWN:  dir_to_keys = 10'h004;
      DIR_LEFT:  dir_to_keys = 10'h010;
      DIR_RIGHT: dir_to_keys = 10'h040;
      default:   dir_to_keys = 10'h000;
    endcase
  endfunction

  function automatic logic [1:0] dir_to_code(input dir_t d);
    case (d)
      DIR_UP:    dir_to_code = 2'b11;
      DIR_DOWN:  dir_to_code = 2'b00;
      DIR_LEFT:  dir_to_code = 2'b10;
      default:   dir_to_code = 2'b01;
    endcase
  endfunction

  db_st_t     st, st_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] code, code_n;
  dir_t       cur, cur_n;
  dir_t       pend, pend_n;
  logic [5:0] tmo, tmo_n;
  logic       col_seen, col_seen_n;
  logic       req;
  dir_t       req_dir;
  logic       sof_act;
  logic [9:0] keys_r;
  logic [1:0] code_r;
  logic       pvld_r;

  // A frozen block ignores frame pulses entirely.
  assign sof_act = startOfFrame & ~stop;

  // Debounce FSM: next state, press counter and one-shot request.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    code_n = code;
    req    = 1'b0;
    if (sof_act) begin
      case (st)
        WAIT_ST: begin
          if (keyIsPressed && is_valid_key(keyCode)) begin
            code_n = keyCode;
            cnt_n  = 4'd1;
            if (cnt_n >= DEB_LIM) begin
              req  = 1'b1;
              st_n = HELD_ST;
            end else begin
              st_n = COUNT_ST;
            end
          end
        end
        COUNT_ST: begin
          if (keyIsPressed && keyCode == code) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n >= DEB_LIM) begin
              req  = 1'b1;
              st_n = HELD_ST;
            end
          end else if (keyIsPressed && is_valid_key(keyCode)) begin
            // A different valid key restarts counting in this same frame.
            code_n = keyCode;
            cnt_n  = 4'd1;
            if (cnt_n >= DEB_LIM) begin
              req  = 1'b1;
              st_n = HELD_ST;
            end else begin
              st_n = COUNT_ST;
            end
          end else begin
            cnt_n = 4'd0;
            st_n  = WAIT_ST;
          end
        end
        HELD_ST: begin
          if (!keyIsPressed || keyCode != code) begin
            cnt_n = 4'd0;
            st_n  = WAIT_ST;
          end
        end
        default: begin
          cnt_n = 4'd0;
          st_n  = WAIT_ST;
        end
      endcase
    end
  end

  assign req_dir = key_to_dir(code_n);

  // Direction commit: new requests first, otherwise retry the pending turn.
  always_comb begin
    cur_n      = cur;
    pend_n     = pend;
    tmo_n      = tmo;
    col_seen_n = col_seen;
    if (sof_act) begin
      // Collision in the frame-pulse cycle counts toward the new frame.
      col_seen_n = collision;
      if (req) begin
        if (code_n == KEY_HALT) begin
          cur_n  = DIR_NONE;
          pend_n = DIR_NONE;
        end else if (req_dir == cur) begin
          pend_n = DIR_NONE;
        end else if (cur == DIR_NONE || req_dir == reverse_of(cur)) begin
          cur_n  = req_dir;
          pend_n = DIR_NONE;
        end else begin
          pend_n = req_dir;
          tmo_n  = 6'd0;
        end
      end else if (pend != DIR_NONE) begin
        if (!col_seen) begin
          cur_n  = pend;
          pend_n = DIR_NONE;
          tmo_n  = 6'd0;
        end else begin
          tmo_n = tmo + 6'd1;
          if (tmo_n >= TMO_LIM) begin
            pend_n = DIR_NONE;
            tmo_n  = 6'd0;
          end
        end
      end
    end else if (!stop && collision) begin
      col_seen_n = 1'b1;
    end
  end

  // State and registered outputs; sync restart mirrors the async reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st       <= WAIT_ST;
      cnt      <= 4'd0;
      code     <= 4'd0;
      cur      <= DIR_NONE;
      pend     <= DIR_NONE;
      tmo      <= 6'd0;
      col_seen <= 1'b0;
      keys_r   <= 10'h000;
      code_r   <= 2'b01;
      pvld_r   <= 1'b0;
    end else if (reset) begin
      st       <= WAIT_ST;
      cnt      <= 4'd0;
      code     <= 4'd0;
      cur      <= DIR_NONE;
      pend     <= DIR_NONE;
      tmo      <= 6'd0;
      col_seen <= 1'b0;
      keys_r   <= 10'h000;
      code_r   <= 2'b01;
      pvld_r   <= 1'b0;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      code     <= code_n;
      cur      <= cur_n;
      pend     <= pend_n;
      tmo      <= tmo_n;
      col_seen <= col_seen_n;
      keys_r   <= dir_to_keys(cur_n);
      if (cur_n != DIR_NONE) begin
        code_r <= dir_to_code(cur_n);
      end
      pvld_r   <= (pend_n != DIR_NONE);
    end
  end

  assign dirKeys      = stop ? 10'h000 : keys_r;
  assign dirCode      = code_r;
  assign pendingValid = pvld_r;

endmodule
